// File: rtl/load_arbiter.sv
// load_arbiter: round-robin owner selection for the shared tile loader.
// Captures the winner's address/length, issues one load command, steers
// tile strobes and completion back to the owner, and checks the tile count.
module load_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int TILE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [24*NUM_REQ-1:0] req_addr,
    input  logic [20*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    tile_valid,
    output logic [TILE_WIDTH-1:0] tile_data,
    output logic [NUM_REQ-1:0]    done,
    output logic                  len_err,
    output logic                  busy,
    output logic                  ld_valid_in,
    output logic [23:0]           ld_dram_addr,
    output logic [19:0]           ld_length,
    input  logic                  ld_tile_out,
    input  logic                  ld_valid_out,
    input  logic [TILE_WIDTH-1:0] ld_data_out
);

    localparam int NUM_BYTES = TILE_WIDTH / 8;
    localparam int SHIFT     = $clog2(NUM_BYTES);
    localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ARB, ISSUE, BUSY, RELEASE} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant_idx;
    logic [15:0]     tile_cnt;
    logic [15:0]     exp_tiles;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [23:0]     sel_addr;
    logic [19:0]     sel_len;
    logic [20:0]     len_round;
    logic [15:0]     exp_next;

    assign tile_data = ld_data_out;

    // Cyclic search for the first requester at or after rr_ptr, plus its tile count.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        pick_onehot = '0;
        sel_addr    = '0;
        sel_len     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found        = 1'b1;
                pick_idx          = cand;
                pick_onehot       = '0;
                pick_onehot[cand] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (pick_found && pick_idx == IW'(j)) begin
                sel_addr = req_addr[24*j +: 24];
                sel_len  = req_len[20*j +: 20];
            end
        end
        // 21-bit sum so a maximal length cannot wrap before the shift
        len_round = {1'b0, sel_len} + 21'(NUM_BYTES - 1);
        exp_next  = 16'(len_round >> SHIFT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        state_next  = state;
        busy        = (state != ARB);
        ld_valid_in = 1'b0;
        tile_valid  = '0;
        done        = '0;
        len_err     = 1'b0;
        case (state)
            ARB: begin
                if (pick_found) begin
                    state_next = (sel_len == '0) ? RELEASE : ISSUE;
                end
            end
            ISSUE: begin
                ld_valid_in = 1'b1;
                state_next  = BUSY;
            end
            BUSY: begin
                tile_valid = grant & {NUM_REQ{ld_tile_out}};
                if (ld_valid_out) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                done       = grant;
                len_err    = (tile_cnt != exp_tiles);
                state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    // Grant, captured command, tile accounting and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant        <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            ld_dram_addr <= '0;
            ld_length    <= '0;
            tile_cnt     <= '0;
            exp_tiles    <= '0;
        end else begin
            case (state)
                ARB: begin
                    tile_cnt <= '0;
                    if (pick_found) begin
                        grant        <= pick_onehot;
                        grant_idx    <= pick_idx;
                        ld_dram_addr <= sel_addr;
                        ld_length    <= sel_len;
                        exp_tiles    <= exp_next;
                    end
                end
                BUSY: begin
                    if (ld_tile_out) begin
                        tile_cnt <= tile_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    grant  <= '0;
                    rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_arbiter.sv
// tb_load_arbiter: directed scenarios against a behavioural tile loader.
module tb_load_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int TILE_WIDTH = 256;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [24*NUM_REQ-1:0] req_addr;
    logic [20*NUM_REQ-1:0] req_len;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    tile_valid;
    logic [TILE_WIDTH-1:0] tile_data;
    logic [NUM_REQ-1:0]    done;
    logic                  len_err;
    logic                  busy;
    logic                  ld_valid_in;
    logic [23:0]           ld_dram_addr;
    logic [19:0]           ld_length;
    logic                  ld_tile_out;
    logic                  ld_valid_out;
    logic [TILE_WIDTH-1:0] ld_data_out;

    logic model_tile;
    logic model_valid;
    logic spur_tile;
    logic drop_en;

    assign ld_tile_out  = model_tile | spur_tile;
    assign ld_valid_out = model_valid;

    int n_cmp = 0;
    int n_err = 0;

    int tile_seen [NUM_REQ];
    int done_seen [NUM_REQ];
    int err_seen   = 0;
    int cmd_seen   = 0;
    int done_total = 0;
    int order_q[$];

    int tile_base [NUM_REQ];
    int done_base [NUM_REQ];
    int err_base, cmd_base, order_base;

    load_arbiter #(.NUM_REQ(NUM_REQ), .TILE_WIDTH(TILE_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .grant        (grant),
        .tile_valid   (tile_valid),
        .tile_data    (tile_data),
        .done         (done),
        .len_err      (len_err),
        .busy         (busy),
        .ld_valid_in  (ld_valid_in),
        .ld_dram_addr (ld_dram_addr),
        .ld_length    (ld_length),
        .ld_tile_out  (ld_tile_out),
        .ld_valid_out (ld_valid_out),
        .ld_data_out  (ld_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"},       256'(grant),        256'(0));
        check({tag, "_tile_valid"},  256'(tile_valid),   256'(0));
        check({tag, "_done"},        256'(done),         256'(0));
        check({tag, "_len_err"},     256'(len_err),      256'(0));
        check({tag, "_busy"},        256'(busy),         256'(0));
        check({tag, "_ld_valid_in"}, 256'(ld_valid_in),  256'(0));
        check({tag, "_ld_addr"},     256'(ld_dram_addr), 256'(0));
        check({tag, "_ld_len"},      256'(ld_length),    256'(0));
    endtask

    task automatic set_client(input int i, input logic [23:0] addr, input logic [19:0] len);
        req_addr[24*i +: 24] = addr;
        req_len[20*i +: 20]  = len;
    endtask

    task automatic snap();
        for (int i = 0; i < NUM_REQ; i++) begin
            tile_base[i] = tile_seen[i];
            done_base[i] = done_seen[i];
        end
        err_base   = err_seen;
        cmd_base   = cmd_seen;
        order_base = order_q.size();
    endtask

    // Waits for n more done pulses; clients drop req on their own done.
    task automatic wait_dones(input string tag, input int n, input int budget);
        int start;
        int cyc;
        start = done_total;
        cyc   = 0;
        while ((done_total - start) < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            req = req & ~done;
        end
        if ((done_total - start) < n) begin
            check({tag, "_timeout_dones"}, 256'(done_total - start), 256'(n));
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Behavioural loader: one strobe per 32-byte tile, then a held done level.
    initial begin
        int ntiles;
        model_tile  = 1'b0;
        model_valid = 1'b0;
        ld_data_out = '0;
        forever begin
            @(negedge clk);
            if (rst_n && ld_valid_in) begin
                ntiles = (int'(ld_length) + 31) / 32;
                if (drop_en && ld_length == 20'd64) ntiles = ntiles - 1;
                @(posedge clk); #1;
                model_valid = 1'b0;
                for (int k = 0; k < ntiles && rst_n; k++) begin
                    model_tile  = 1'b1;
                    ld_data_out = {8{32'hC0DE_0000 + 32'(k)}};
                    @(posedge clk); #1;
                    model_tile = 1'b0;
                    @(posedge clk); #1;
                end
                model_valid = rst_n;
            end else if (!rst_n) begin
                model_valid = 1'b0;
            end
        end
    end

    // Event counters and per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tile_valid[i]) tile_seen[i]++;
                if (done[i]) begin
                    done_seen[i]++;
                    done_total++;
                    order_q.push_back(i);
                end
            end
            if (len_err) begin
                err_seen++;
                check("len_err_with_done", 256'(done != '0), 256'(1));
            end
            if (ld_valid_in) cmd_seen++;
            if (tile_valid != '0) check("tile_data", tile_data, ld_data_out);
        end
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_len   = '0;
        spur_tile = 1'b0;
        drop_en   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tile_seen[i] = 0;
            done_seen[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single client 0, 64 bytes -> two tiles
        snap();
        set_client(0, 24'h000100, 20'd64);
        req = 3'b001;
        @(negedge clk);
        check("t1_grant",       256'(grant),        256'(3'b001));
        check("t1_ld_valid_in", 256'(ld_valid_in),  256'(1));
        check("t1_ld_addr",     256'(ld_dram_addr), 256'(24'h000100));
        check("t1_ld_len",      256'(ld_length),    256'(20'd64));
        wait_dones("t1", 1, 60);
        @(negedge clk);
        check("t1_grant_idle", 256'(grant), 256'(0));
        check("t1_cmds",   256'(cmd_seen - cmd_base),         256'(1));
        check("t1_tiles0", 256'(tile_seen[0] - tile_base[0]), 256'(2));
        check("t1_done0",  256'(done_seen[0] - done_base[0]), 256'(1));
        check("t1_err",    256'(err_seen - err_base),         256'(0));

        // Three clients, then client 0 re-requests while client 2 waits
        reset_dut();
        snap();
        set_client(0, 24'h001000, 20'd32);
        set_client(1, 24'h002000, 20'd32);
        set_client(2, 24'h003000, 20'd32);
        req = 3'b111;
        wait_dones("t2a", 1, 60);
        req[0] = 1'b1;
        wait_dones("t2b", 3, 200);
        check("t2_order0", 256'(order_q[order_base + 0]), 256'(0));
        check("t2_order1", 256'(order_q[order_base + 1]), 256'(1));
        check("t2_order2", 256'(order_q[order_base + 2]), 256'(2));
        check("t2_order3", 256'(order_q[order_base + 3]), 256'(0));
        check("t2_cmds",   256'(cmd_seen - cmd_base),         256'(4));
        check("t2_tiles0", 256'(tile_seen[0] - tile_base[0]), 256'(2));
        check("t2_tiles2", 256'(tile_seen[2] - tile_base[2]), 256'(1));

        // Length 33 -> ceiling gives two tiles
        @(negedge clk);
        snap();
        set_client(1, 24'h004000, 20'd33);
        req = 3'b010;
        wait_dones("t3", 1, 60);
        check("t3_tiles1", 256'(tile_seen[1] - tile_base[1]), 256'(2));
        check("t3_done1",  256'(done_seen[1] - done_base[1]), 256'(1));
        check("t3_err",    256'(err_seen - err_base),         256'(0));

        // Zero length completes locally without a loader command
        @(negedge clk);
        snap();
        set_client(2, 24'h005000, 20'd0);
        req = 3'b100;
        @(negedge clk);
        check("t4_grant",       256'(grant),       256'(3'b100));
        check("t4_done",        256'(done),        256'(3'b100));
        check("t4_ld_valid_in", 256'(ld_valid_in), 256'(0));
        check("t4_len_err",     256'(len_err),     256'(0));
        req = '0;
        @(negedge clk);
        check("t4_done_after", 256'(done), 256'(0));
        check("t4_busy_after", 256'(busy), 256'(0));
        check("t4_cmds",   256'(cmd_seen - cmd_base),         256'(0));
        check("t4_tiles2", 256'(tile_seen[2] - tile_base[2]), 256'(0));

        // Loader drops a strobe on the 64-byte transfer -> len_err, then next client
        snap();
        drop_en = 1'b1;
        set_client(0, 24'h006000, 20'd64);
        set_client(1, 24'h007000, 20'd32);
        req = 3'b011;
        wait_dones("t5a", 1, 60);
        check("t5_err_first",   256'(err_seen - err_base),         256'(1));
        check("t5_tiles0",      256'(tile_seen[0] - tile_base[0]), 256'(1));
        check("t5_order_first", 256'(order_q[order_base]),         256'(0));
        wait_dones("t5b", 1, 60);
        check("t5_order_next",  256'(order_q[order_base + 1]),     256'(1));
        check("t5_err_total",   256'(err_seen - err_base),         256'(1));
        check("t5_tiles1",      256'(tile_seen[1] - tile_base[1]), 256'(1));
        drop_en = 1'b0;

        // Stale done level plus spurious strobes while idle
        @(negedge clk);
        snap();
        @(posedge clk); #1;
        spur_tile = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur_tile = 1'b0;
        @(negedge clk);
        check("t6_idle_tiles", 256'(tile_seen[0] + tile_seen[1] + tile_seen[2]
                                    - tile_base[0] - tile_base[1] - tile_base[2]), 256'(0));
        check("t6_idle_done",  256'(done_total), 256'(done_seen[0] + done_seen[1] + done_seen[2]));
        check("t6_idle_busy",  256'(busy), 256'(0));
        set_client(2, 24'h008000, 20'd32);
        req = 3'b100;
        @(negedge clk);
        check("t6_issue", 256'(ld_valid_in), 256'(1));
        @(negedge clk);
        check("t6_no_early_done", 256'(done), 256'(0));
        wait_dones("t6", 1, 60);
        check("t6_tiles2", 256'(tile_seen[2] - tile_base[2]), 256'(1));
        check("t6_err",    256'(err_seen - err_base),         256'(0));

        // Move rr_ptr off zero, then reset in the middle of a long transfer
        @(negedge clk);
        set_client(1, 24'h009000, 20'd32);
        req = 3'b010;
        wait_dones("t7a", 1, 60);
        @(negedge clk);
        set_client(1, 24'h00A000, 20'd320);
        req = 3'b010;
        repeat (5) @(negedge clk);
        check("t7_busy_pre", 256'(busy), 256'(1));
        snap();
        rst_n = 1'b0;
        #1;
        check_idle("t7_async");
        set_client(0, 24'h00B000, 20'd32);
        set_client(1, 24'h00C000, 20'd32);
        set_client(2, 24'h00D000, 20'd32);
        req = 3'b111;
        repeat (3) @(negedge clk);
        check("t7_no_done", 256'(done_seen[1] - done_base[1]), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_first_grant", 256'(grant), 256'(3'b001));
        wait_dones("t7b", 3, 200);
        check("t7_order0", 256'(order_q[order_base + 0]), 256'(0));
        check("t7_order1", 256'(order_q[order_base + 1]), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
